border_collision_multi: RTL and testbench

// - Frame-synchronous border-bounce controller for N_BALLS balls on the billiard table.
// - Latches pixel-level ball/border overlaps during a frame and reflects velocities once per frame at startOfFrame.
// - Applies a per-ball cooldown and a direction check, so a ball embedded in the cushion cannot oscillate.
// - Sits between the drawing-request mux (DR inputs) and the per-ball velocity/position movers.

---
 rtl/border_collision_multi.sv | 175 +++++++++++++++++
 tb/tb_border_collision_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/border_collision_multi.sv
// Frame-synchronous border bounce for N_BALLS balls: pixel overlaps latched per frame, reflected at startOfFrame.
// Optional BORDER_DAMPING_EN attenuates reflected axes by v >>> DAMP_SHIFT before negation.
module border_collision_lane #(
  parameter int POS_W           = 11,
  parameter int VEL_W           = 11,
  parameter int TOP_OFFSET      = 40,
  parameter int DOWN_OFFSET     = 440,
  parameter int LEFT_OFFSET     = 30,
  parameter int RIGHT_OFFSET    = 600,
  parameter int COOLDOWN_FRAMES = 2,
  parameter int DAMP_SHIFT      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startOfFrame,
  input  logic             hit,
  input  logic [POS_W-1:0] posX,
  input  logic [POS_W-1:0] posY,
  input  logic [VEL_W-1:0] velX,
  input  logic [VEL_W-1:0] velY,
  output logic [VEL_W-1:0] velXOut,
  output logic [VEL_W-1:0] velYOut,
  output logic             collision,
  output logic             inCooldown
);
`ifdef BORDER_DAMPING_EN
  localparam bit DAMP_ON = 1'b1;
`else
  localparam bit DAMP_ON = 1'b0;
`endif
  localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic signed [POS_W-1:0] TOP   = POS_W'(TOP_OFFSET);
  localparam logic signed [POS_W-1:0] DOWN  = POS_W'(DOWN_OFFSET);
  localparam logic signed [POS_W-1:0] LEFT  = POS_W'(LEFT_OFFSET);
  localparam logic signed [POS_W-1:0] RIGHT = POS_W'(RIGHT_OFFSET);
  localparam logic signed [VEL_W+1:0] VMAX  = {3'b000, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W+1:0] VMIN  = {3'b111, {(VEL_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PENDING, COOLDOWN} state_t;

  state_t           state;
  logic             flagX, flagY;
  logic [CNT_W-1:0] cnt;
  logic signed [POS_W-1:0] x, y;
  logic             negX, posVX, negY, posVY, newX, newY;

  assign x     = $signed(posX);
  assign y     = $signed(posY);
  assign negX  = velX[VEL_W-1];
  assign posVX = !velX[VEL_W-1] && (velX != '0);
  assign negY  = velY[VEL_W-1];
  assign posVY = !velY[VEL_W-1] && (velY != '0);
  // Only flag an axis when the ball is still heading into that cushion.
  assign newX  = (x <= LEFT && negX) || (x >= RIGHT && posVX);
  assign newY  = (y <= TOP && negY) || (y >= DOWN && posVY);
  assign inCooldown = (cnt != '0);

  function automatic logic [VEL_W-1:0] reflect(input logic [VEL_W-1:0] v);
    logic signed [VEL_W+1:0] w, r;
    w = $signed({{2{v[VEL_W-1]}}, v});
    if (DAMP_ON) w = w - (w >>> DAMP_SHIFT);
    r = -w;
    if (r > VMAX)      return VMAX[VEL_W-1:0];
    else if (r < VMIN) return VMIN[VEL_W-1:0];
    else               return r[VEL_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      flagX     <= 1'b0;
      flagY     <= 1'b0;
      cnt       <= '0;
      velXOut   <= '0;
      velYOut   <= '0;
      collision <= 1'b0;
    end else begin
      velXOut   <= velX;
      velYOut   <= velY;
      collision <= 1'b0;
      case (state)
        IDLE: if (hit) begin
          state <= PENDING;
          flagX <= newX;
          flagY <= newY;
        end
        PENDING: if (startOfFrame) begin
          // Decision uses flags from before this cycle; a same-cycle hit seeds the next frame.
          if (flagX) velXOut <= reflect(velX);
          if (flagY) velYOut <= reflect(velY);
          collision <= flagX | flagY;
          if ((flagX || flagY) && COOLDOWN_FRAMES > 0) begin
            state <= COOLDOWN;
            cnt   <= CNT_W'(COOLDOWN_FRAMES);
            flagX <= 1'b0;
            flagY <= 1'b0;
          end else if (hit) begin
            flagX <= newX;
            flagY <= newY;
          end else begin
            state <= IDLE;
            flagX <= 1'b0;
            flagY <= 1'b0;
          end
        end else if (hit) begin
          flagX <= flagX | newX;
          flagY <= flagY | newY;
        end
        COOLDOWN: if (startOfFrame) begin
          if (cnt == CNT_W'(1)) begin
            cnt <= '0;
            if (hit) begin
              state <= PENDING;
              flagX <= newX;
              flagY <= newY;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module border_collision_multi #(
  parameter int N_BALLS         = 16,
  parameter int POS_W           = 11,
  parameter int VEL_W           = 11,
  parameter int TOP_OFFSET      = 40,
  parameter int DOWN_OFFSET     = 440,
  parameter int LEFT_OFFSET     = 30,
  parameter int RIGHT_OFFSET    = 600,
  parameter int COOLDOWN_FRAMES = 2,
  parameter int DAMP_SHIFT      = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     startOfFrame,
  input  logic                     borderDR,
  input  logic [N_BALLS-1:0]       ballDR,
  input  logic [N_BALLS*POS_W-1:0] ballTopLeftPosX,
  input  logic [N_BALLS*POS_W-1:0] ballTopLeftPosY,
  input  logic [N_BALLS*VEL_W-1:0] ballVelX,
  input  logic [N_BALLS*VEL_W-1:0] ballVelY,
  output logic [N_BALLS*VEL_W-1:0] ballVelXOut,
  output logic [N_BALLS*VEL_W-1:0] ballVelYOut,
  output logic [N_BALLS-1:0]       collisionOccurred,
  output logic [N_BALLS-1:0]       inCooldown
);
  for (genvar i = 0; i < N_BALLS; i++) begin : g_ball
    border_collision_lane #(
      .POS_W(POS_W), .VEL_W(VEL_W),
      .TOP_OFFSET(TOP_OFFSET), .DOWN_OFFSET(DOWN_OFFSET),
      .LEFT_OFFSET(LEFT_OFFSET), .RIGHT_OFFSET(RIGHT_OFFSET),
      .COOLDOWN_FRAMES(COOLDOWN_FRAMES), .DAMP_SHIFT(DAMP_SHIFT)
    ) u_lane (
      .clk          (clk),
      .reset        (reset),
      .startOfFrame (startOfFrame),
      .hit          (ballDR[i] & borderDR),
      .posX         (ballTopLeftPosX[i*POS_W +: POS_W]),
      .posY         (ballTopLeftPosY[i*POS_W +: POS_W]),
      .velX         (ballVelX[i*VEL_W +: VEL_W]),
      .velY         (ballVelY[i*VEL_W +: VEL_W]),
      .velXOut      (ballVelXOut[i*VEL_W +: VEL_W]),
      .velYOut      (ballVelYOut[i*VEL_W +: VEL_W]),
      .collision    (collisionOccurred[i]),
      .inCooldown   (inCooldown[i])
    );
  end
endmodule

// File: tb/tb_border_collision_multi.sv
// Bench for border_collision_multi: directed cases with literal expectations plus randomized traffic vs a frame-level model.
module tb_border_collision_multi;
  localparam int N     = 16;
  localparam int POS_W = 11;
  localparam int VEL_W = 11;
  localparam int COOL  = 2;

  logic clk = 1'b0, reset = 1'b1, sof = 1'b0, bdr = 1'b0;
  logic [N-1:0] dr = '0;
  logic [N-1:0][POS_W-1:0] px = '0, py = '0;
  logic [N-1:0][VEL_W-1:0] vx = '0, vy = '0;
  logic [N-1:0][VEL_W-1:0] vxo, vyo;
  logic [N-1:0] coll, incool;

  int n_tests = 0, n_fail = 0, cycle = 0;

  border_collision_multi #(
    .N_BALLS(N), .POS_W(POS_W), .VEL_W(VEL_W), .TOP_OFFSET(40), .DOWN_OFFSET(440),
    .LEFT_OFFSET(30), .RIGHT_OFFSET(600), .COOLDOWN_FRAMES(COOL), .DAMP_SHIFT(3)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .borderDR(bdr), .ballDR(dr),
    .ballTopLeftPosX(px), .ballTopLeftPosY(py), .ballVelX(vx), .ballVelY(vy),
    .ballVelXOut(vxo), .ballVelYOut(vyo), .collisionOccurred(coll), .inCooldown(incool)
  );

  always #5 clk = ~clk;

  // ---- frame-level reference model ----
  bit pend[N], fx[N], fy[N];
  int cool[N];
  logic [N-1:0][VEL_W-1:0] ex, ey;
  logic [N-1:0] ec, ecl;
  logic s_rst, s_sof, s_bdr;
  logic [N-1:0] s_dr;
  logic [N-1:0][POS_W-1:0] s_px, s_py;
  logic [N-1:0][VEL_W-1:0] s_vx, s_vy;

  function automatic int refl(int v);
    int r;
`ifdef BORDER_DAMPING_EN
    r = -(v - (v >>> 3));
`else
    r = -v;
`endif
    if (r > 1023) r = 1023;
    if (r < -1024) r = -1024;
    return r;
  endfunction

  task automatic model_step(int i);
    int x, y, a, b, ox, oy;
    bit hit, nfx, nfy;
    x = int'($signed(s_px[i])); y = int'($signed(s_py[i]));
    a = int'($signed(s_vx[i])); b = int'($signed(s_vy[i]));
    hit = s_bdr & s_dr[i];
    nfx = (x <= 30 && a < 0) || (x >= 600 && a > 0);
    nfy = (y <= 40 && b < 0) || (y >= 440 && b > 0);
    ox = a; oy = b; ec[i] = 1'b0;
    if (s_sof) begin
      if (cool[i] > 0) cool[i]--;
      else if (pend[i]) begin
        if (fx[i] || fy[i]) begin
          if (fx[i]) ox = refl(a);
          if (fy[i]) oy = refl(b);
          ec[i] = 1'b1;
          cool[i] = COOL;
        end
        pend[i] = 0; fx[i] = 0; fy[i] = 0;
      end
    end
    if (cool[i] == 0 && hit) begin
      if (pend[i]) begin fx[i] |= nfx; fy[i] |= nfy; end
      else begin fx[i] = nfx; fy[i] = nfy; end
      pend[i] = 1;
    end
    ex[i] = ox[VEL_W-1:0];
    ey[i] = oy[VEL_W-1:0];
    ecl[i] = (cool[i] > 0);
  endtask

  always @(posedge clk) begin
    s_rst = reset; s_sof = sof; s_bdr = bdr; s_dr = dr;
    s_px = px; s_py = py; s_vx = vx; s_vy = vy;
    cycle++;
    if (s_rst) begin
      for (int i = 0; i < N; i++) begin pend[i] = 0; fx[i] = 0; fy[i] = 0; cool[i] = 0; end
      ex = '0; ey = '0; ec = '0; ecl = '0;
    end else begin
      for (int i = 0; i < N; i++) model_step(i);
    end
    #1;
    n_tests += 4;
    if (vxo !== ex) begin n_fail++; $display("FAIL velXOut cyc %0d: got %h want %h", cycle, vxo, ex); end
    if (vyo !== ey) begin n_fail++; $display("FAIL velYOut cyc %0d: got %h want %h", cycle, vyo, ey); end
    if (coll !== ec) begin n_fail++; $display("FAIL collision cyc %0d: got %h want %h", cycle, coll, ec); end
    if (incool !== ecl) begin n_fail++; $display("FAIL inCooldown cyc %0d: got %h want %h", cycle, incool, ecl); end
  end

  // ---- directed helpers ----
  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL %s: got %0d want %0d", name, act, exp); end
  endtask

  task automatic cyc(logic s, logic b, logic [N-1:0] d);
    sof = s; bdr = b; dr = d;
    @(negedge clk);
  endtask

  task automatic set_ball(int i, int x, int y, int a, int b);
    px[i] = POS_W'(x); py[i] = POS_W'(y); vx[i] = VEL_W'(a); vy[i] = VEL_W'(b);
  endtask

  task automatic do_reset();
    sof = 0; bdr = 0; dr = '0; reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int rpos(bit isy);
    case ($urandom_range(0, 4))
      0: return isy ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 30));
      1: return isy ? int'($urandom_range(440, 500)) : int'($urandom_range(600, 700));
      2: return -int'($urandom_range(1, 20));
      default: return isy ? int'($urandom_range(41, 439)) : int'($urandom_range(31, 599));
    endcase
  endfunction

  function automatic int rvel();
    case ($urandom_range(0, 9))
      0: return -1024;
      1: return 1023;
      2: return 0;
      default: return int'($urandom_range(0, 40)) - 20;
    endcase
  endfunction

  int e1, e5, e6;
  logic [N-1:0] rdr;

  initial begin
`ifdef BORDER_DAMPING_EN
    e1 = 4; e5 = 896; e6 = -14;
`else
    e1 = 5; e5 = 1023; e6 = -16;
`endif
    @(negedge clk); @(negedge clk);
    chk("reset_velx", int'(vxo != '0), 0);
    chk("reset_coll", int'(coll), 0);
    chk("reset_cool", int'(incool), 0);
    reset = 1'b0;

    // left wall, heading in: X reflected, Y untouched, single pulse
    set_ball(0, 25, 200, -5, 7);
    cyc(0, 1, 16'h0001); cyc(0, 1, 16'h0001); cyc(0, 1, 16'h0001);
    cyc(1, 0, '0);
    chk("t1_velx", int'($signed(vxo[0])), e1);
    chk("t1_vely", int'($signed(vyo[0])), 7);
    chk("t1_pulse", int'(coll[0]), 1);
    cyc(0, 0, '0);
    chk("t1_pulse_end", int'(coll[0]), 0);
    chk("t1_cool", int'(incool[0]), 1);

    // corner hit reflects both axes in one pulse
    do_reset();
    set_ball(1, 605, 445, 3, 4);
    cyc(0, 1, 16'h0002); cyc(1, 0, '0);
    chk("t2_velx", int'($signed(vxo[1])), -3);
    chk("t2_vely", int'($signed(vyo[1])), -4);
    chk("t2_pulse", int'(coll), 16'h0002);

    // moving away: no reflection, no pulse, back in IDLE
    do_reset();
    set_ball(2, 25, 200, 5, 0);
    cyc(0, 1, 16'h0004); cyc(1, 0, '0);
    chk("t3_velx", int'($signed(vxo[2])), 5);
    chk("t3_pulse", int'(coll[2]), 0);
    chk("t3_cool", int'(incool[2]), 0);
    cyc(0, 0, '0); cyc(1, 0, '0);
    chk("t3_idle_sof", int'(coll[2]), 0);

    // cooldown: two frames of hits ignored, third frame reflects
    do_reset();
    set_ball(4, 25, 200, -5, 0);
    cyc(0, 1, 16'h0010); cyc(1, 0, '0);
    chk("t4_first", int'(coll[4]), 1);
    cyc(0, 1, 16'h0010); cyc(0, 1, 16'h0010);
    chk("t4_cool_f1", int'(incool[4]), 1);
    cyc(1, 0, '0);
    chk("t4_nopulse_f1", int'(coll[4]), 0);
    chk("t4_cool_f2", int'(incool[4]), 1);
    cyc(0, 1, 16'h0010); cyc(1, 0, '0);
    chk("t4_nopulse_f2", int'(coll[4]), 0);
    chk("t4_cool_done", int'(incool[4]), 0);
    cyc(0, 1, 16'h0010); cyc(1, 0, '0);
    chk("t4_again", int'(coll[4]), 1);

    // saturation at left wall and right-wall reflection of +16
    do_reset();
    set_ball(5, 25, 200, -1024, 0);
    set_ball(6, 605, 200, 16, 0);
    cyc(0, 1, 16'h0060); cyc(1, 0, '0);
    chk("t5_sat", int'($signed(vxo[5])), e5);
    chk("t5_right16", int'($signed(vxo[6])), e6);

    // async reset while balls 3 and 7 pending
    do_reset();
    set_ball(3, 25, 100, -5, 1);
    set_ball(7, 605, 100, 6, 1);
    cyc(0, 1, 16'h0088);
    chk("t6_pre", int'($signed(vxo[3])), -5);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_vx", int'(vxo != '0), 0);
    chk("t6_rst_vy", int'(vyo != '0), 0);
    chk("t6_rst_coll", int'(coll), 0);
    chk("t6_rst_cool", int'(incool), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 0, '0);
    chk("t6_no_pulse", int'(coll), 0);
    chk("t6_vx_pass", int'($signed(vxo[3])), -5);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) set_ball(i, rpos(0), rpos(1), rvel(), rvel());
        rdr[i] = ($urandom_range(0, 3) == 0);
      end
      if (c == 2500) begin
        reset = 1'b1; @(negedge clk); reset = 1'b0;
      end
      cyc(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, rdr);
    end
    cyc(0, 0, '0); cyc(0, 0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end
endmodule
